// File: rtl/evo_pkg.sv
// Shared types and helpers for the evolvable gate array: opcodes, FSM states,
// genome field widths and the per-gate boolean function.
package evo_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_BUF  = 3'd7
  } evo_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } evo_state_t;

  function automatic int evo_sel_w(input int n_in, input int n_g);
    return $clog2(n_in + n_g);
  endfunction

  function automatic int evo_genome_w(input int sel_w);
    return OP_W + 2 * sel_w;
  endfunction

  // Keeps the address port at least one bit wide for a single-gate array.
  function automatic int evo_addr_w(input int n_g);
    return (n_g > 1) ? $clog2(n_g) : 1;
  endfunction

  function automatic logic evo_eval(input evo_op_t op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NOT:  r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/evo_gate.sv
// One registered gate cell: genome register, two source muxes, boolean
// function and an output register that only advances while the array runs.
module evo_gate
  import evo_pkg::*;
#(
  parameter int  NUM_INPUTS = 2,
  parameter int  NUM_GATES  = 7,
  parameter int  SEL_W      = evo_sel_w(NUM_INPUTS, NUM_GATES),
  localparam int GEN_W      = evo_genome_w(SEL_W)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [GEN_W-1:0]      cfg_data,
  input  logic [NUM_INPUTS-1:0] in,
  input  logic [NUM_GATES-1:0]  w,
  input  logic                  clr,
  input  logic                  en,
  output logic                  d,
  output logic                  q
);

  logic [GEN_W-1:0] genome;
  evo_op_t          op;
  logic [SEL_W-1:0] src_a;
  logic [SEL_W-1:0] src_b;
  logic             a;
  logic             b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      genome <= '0;
    end else if (we) begin
      genome <= cfg_data;
    end
  end

  assign op    = evo_op_t'(genome[GEN_W-1 -: OP_W]);
  assign src_a = genome[2*SEL_W-1 -: SEL_W];
  assign src_b = genome[SEL_W-1:0];

  // Selects past the last gate fall through to constant 0.
  always_comb begin
    a = 1'b0;
    b = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (src_a == SEL_W'(i)) a = in[i];
      if (src_b == SEL_W'(i)) b = in[i];
    end
    for (int j = 0; j < NUM_GATES; j++) begin
      if (src_a == SEL_W'(NUM_INPUTS + j)) a = w[j];
      if (src_b == SEL_W'(NUM_INPUTS + j)) b = w[j];
    end
  end

  assign d = evo_eval(op, a, b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (clr) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/evo_gate_array.sv
// Runtime-configurable synchronous gate network with a start/done evaluation
// FSM that counts output toggles. Optional trace ports behind EVO_TRACE_EN.
module evo_gate_array
  import evo_pkg::*;
#(
  parameter int  NUM_GATES  = 7,
  parameter int  NUM_INPUTS = 2,
  parameter int  SEL_W      = evo_sel_w(NUM_INPUTS, NUM_GATES),
  parameter int  WIN_W      = 16,
  localparam int ADDR_W     = evo_addr_w(NUM_GATES),
  localparam int GEN_W      = evo_genome_w(SEL_W)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] in,
  input  logic                  cfg_we,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [GEN_W-1:0]      cfg_data,
  input  logic [ADDR_W-1:0]     out_sel,
  input  logic [WIN_W-1:0]      win_len,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [WIN_W-1:0]      toggles,
`ifdef EVO_TRACE_EN
  output logic                  out,
  output logic [NUM_GATES-1:0]  dbg_w,
  output logic [WIN_W-1:0]      dbg_cycle
`else
  output logic                  out
`endif
);

  evo_state_t          state;
  logic [NUM_GATES-1:0] w;
  logic [NUM_GATES-1:0] w_d;
  logic [WIN_W-1:0]    cnt;
  logic [WIN_W-1:0]    cnt_nx;
  logic [WIN_W-1:0]    win_q;
  logic [WIN_W-1:0]    tog_q;
  logic [ADDR_W-1:0]   sel_q;
  logic                out_q;
  logic                busy_q;
  logic                done_q;
  logic                accept;
  logic                run;
  logic                cfg_ok;
  logic                sel_d;

  assign accept = (state == ST_IDLE) && start;
  assign run    = (state == ST_RUN);
  assign cfg_ok = (state == ST_IDLE) && cfg_we;
  assign cnt_nx = cnt + 1'b1;

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    evo_gate #(
      .NUM_INPUTS (NUM_INPUTS),
      .NUM_GATES  (NUM_GATES),
      .SEL_W      (SEL_W)
    ) u_gate (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (cfg_ok && (cfg_addr == ADDR_W'(g))),
      .cfg_data (cfg_data),
      .in       (in),
      .w        (w),
      .clr      (accept),
      .en       (run),
      .d        (w_d[g]),
      .q        (w[g])
    );
  end

  // Toggle detection looks at the value the selected gate is about to take.
  always_comb begin
    sel_d = 1'b0;
    for (int j = 0; j < NUM_GATES; j++) begin
      if (sel_q == ADDR_W'(j)) sel_d = w_d[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      win_q  <= '0;
      tog_q  <= '0;
      sel_q  <= '0;
      out_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt   <= '0;
            tog_q <= '0;
            out_q <= 1'b0;
            sel_q <= out_sel;
            win_q <= win_len;
            if (win_len != '0) begin
              state  <= ST_RUN;
              busy_q <= 1'b1;
            end else begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          cnt   <= cnt_nx;
          out_q <= sel_d;
          if (sel_d != out_q) tog_q <= tog_q + 1'b1;
          if (cnt_nx == win_q) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign toggles = tog_q;
  assign out     = out_q;

`ifdef EVO_TRACE_EN
  assign dbg_w     = w;
  assign dbg_cycle = cnt;
`endif

endmodule

// File: tb/tb_evo_gate_array.sv
// Self-checking bench for evo_gate_array: directed scenarios with literal
// expectations plus randomized runs against a behavioural model.
module tb_evo_gate_array;

  localparam int NG = 7;
  localparam int NI = 2;
  localparam int SW = 4;
  localparam int GW = 3 + 2 * SW;
  localparam int AW = 3;
  localparam int WW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NI-1:0] in = '0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [GW-1:0] cfg_data = '0;
  logic [AW-1:0] out_sel = '0;
  logic [WW-1:0] win_len = '0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [WW-1:0] toggles;
  logic          out;

  int errors = 0;
  int checks = 0;

  evo_gate_array #(
    .NUM_GATES  (NG),
    .NUM_INPUTS (NI),
    .WIN_W      (WW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .out_sel  (out_sel),
    .win_len  (win_len),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .toggles  (toggles),
    .out      (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int        ph = 0;            // 0 idle, 1 evaluating, 2 done pulse
  int        gop[NG];
  int        ga[NG];
  int        gb[NG];
  bit [NG-1:0] mw = '0;
  bit        mout = 1'b0;
  int        mtog = 0;
  int        mk = 0;
  int        msel = 0;
  int        mwin = 0;

  function automatic bit srcval(input int s, input bit [NI-1:0] iv, input bit [NG-1:0] wv);
    if (s < NI) return iv[s];
    if (s < NI + NG) return wv[s-NI];
    return 1'b0;
  endfunction

  function automatic bit opval(input int op, input bit a, input bit b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return !(a & b);
      3: return !(a | b);
      4: return a ^ b;
      5: return !(a ^ b);
      6: return !a;
      default: return a;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; mw = '0; mout = 0; mtog = 0; mk = 0; msel = 0; mwin = 0;
      for (int g = 0; g < NG; g++) begin
        gop[g] = 0; ga[g] = 0; gb[g] = 0;
      end
    end else begin
      case (ph)
        0: begin
          if (cfg_we && int'(cfg_addr) < NG) begin
            gop[cfg_addr] = int'(cfg_data) / 256;
            ga[cfg_addr]  = (int'(cfg_data) / 16) % 16;
            gb[cfg_addr]  = int'(cfg_data) % 16;
          end
          if (start) begin
            mw = '0; mout = 0; mtog = 0; mk = 0;
            msel = int'(out_sel);
            mwin = int'(win_len);
            ph = (mwin != 0) ? 1 : 2;
          end
        end
        1: begin
          bit [NG-1:0] nw;
          bit newo;
          for (int g = 0; g < NG; g++)
            nw[g] = opval(gop[g], srcval(ga[g], in, mw), srcval(gb[g], in, mw));
          newo = (msel < NG) ? nw[msel] : 1'b0;
          if (newo != mout) mtog++;
          mout = newo;
          mw = nw;
          mk++;
          if (mk == mwin) ph = 2;
        end
        default: ph = 0;
      endcase
    end
    #1;
    check("busy", busy, ph == 1);
    check("done", done, ph == 2);
    check("out", out, mout);
    check("toggles", toggles, mtog);
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [GW-1:0] gene(input logic [2:0] op, input logic [SW-1:0] a,
                                         input logic [SW-1:0] b);
    return {op, a, b};
  endfunction

  task automatic cfg(input int g, input logic [GW-1:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = AW'(g); cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // mode: 0 quiet, 1 single BUF write to gate0 mid-run, 2 random writes
  task automatic run(input int sel, input int len, input bit rnd_in, input int mode,
                     output int tog);
    int lat;
    @(negedge clk);
    out_sel = AW'(sel); win_len = WW'(len); start = 1'b1;
    if (rnd_in) in = NI'($urandom);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < len + 5) begin
      cfg_we = 1'b0;
      if (rnd_in) in = NI'($urandom);
      if (mode == 1 && lat == 3) begin
        check("busy_at_cfg", busy, 1);
        cfg_we = 1'b1; cfg_addr = '0; cfg_data = gene(3'd7, 4'd2, 4'd0);
      end else if (mode == 2 && $urandom_range(0, 3) == 0) begin
        cfg_we = 1'b1; cfg_addr = AW'($urandom); cfg_data = GW'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    cfg_we = 1'b0;
    check("done_seen", done, 1);
    check("done_lat", lat, len);
    tog = int'(toggles);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int t;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out", out, 0);
    check("rst_toggles", toggles, 0);
    rst_n = 1'b1;

    // ring oscillator
    cfg(0, gene(3'd6, 4'd2, 4'd0));
    run(0, 10, 1, 0, t);
    check("osc_toggles", t, 10);

    // gated input stays low
    cfg(0, gene(3'd0, 4'd0, 4'd2));
    in = 2'b00;
    run(0, 8, 0, 0, t);
    check("gated_toggles", t, 0);

    // two-gate chain, output lags gate1 by one update
    cfg(1, gene(3'd6, 4'd3, 4'd0));
    cfg(2, gene(3'd7, 4'd3, 4'd0));
    run(2, 5, 1, 0, t);
    check("chain_toggles", t, 4);

    // genome write during a run is ignored
    cfg(0, gene(3'd6, 4'd2, 4'd0));
    run(0, 10, 1, 1, t);
    check("busycfg_toggles", t, 10);
    run(0, 10, 1, 0, t);
    check("readback_toggles", t, 10);

    // zero-length window, start held through the done pulse
    @(negedge clk);
    win_len = '0; out_sel = '0; start = 1'b1;
    @(negedge clk);
    check("w0_done", done, 1);
    check("w0_busy", busy, 0);
    check("w0_toggles", toggles, 0);
    @(negedge clk);
    start = 1'b0;
    check("w0_done_clr", done, 0);
    check("w0_idle_busy", busy, 0);
    @(negedge clk);
    check("w0_no_restart", busy, 0);

    // randomized genomes, inputs, selects and lengths
    for (int g = 0; g < NG; g++) cfg(g, GW'($urandom));
    repeat (25) begin
      repeat ($urandom_range(0, 2)) cfg(int'($urandom_range(0, 7)), GW'($urandom));
      run(int'($urandom_range(0, 7)), int'($urandom_range(0, 20)), 1, 2, t);
    end

    // asynchronous reset in the middle of a run
    cfg(0, gene(3'd6, 4'd2, 4'd0));
    @(negedge clk);
    out_sel = '0; win_len = WW'(10); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_out", out, 0);
    check("abort_toggles", toggles, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    in = 2'b00;
    run(0, 10, 0, 0, t);
    check("post_rst_toggles", t, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
